// File: rtl/gcd_pkg.sv
// Shared types for the GCD requester: data width, FSM states
// and the operand pair carried through the request FIFO.
package gcd_pkg;

  localparam int GCD_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } gcd_req_state_t;

  typedef struct packed {
    logic [GCD_W-1:0] u;
    logic [GCD_W-1:0] v;
  } gcd_pair_t;

endpackage

// File: rtl/gcd_req_fifo.sv
// Operand-pair FIFO; pointers carry an extra wrap bit so
// full and empty are told apart without a counter.
module gcd_req_fifo
  import gcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      resetb,
  input  logic      push,
  input  logic      pop,
  input  gcd_pair_t din,
  output gcd_pair_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  gcd_pair_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/gcd_requester.sv
// Sequences buffered operand pairs through one GCD engine, in order.
// Define GCD_REQ_TIMEOUT_EN for the done watchdog and DRAIN state.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [GCD_W-1:0] req_u,
  input  logic [GCD_W-1:0] req_v,
  output logic             gcd_ld,
  output logic [GCD_W-1:0] gcd_u,
  output logic [GCD_W-1:0] gcd_v,
  input  logic [GCD_W-1:0] gcd_res,
  input  logic             gcd_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [GCD_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2)
  begin : g_cfg_check
    $error("gcd_requester: bad DEPTH or TIMEOUT");
  end

  gcd_req_state_t   state;
  gcd_req_state_t   state_n;
  gcd_pair_t        req_pair;
  gcd_pair_t        head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             done_q;
  logic             rise;
  logic [GCD_W-1:0] u_n;
  logic [GCD_W-1:0] v_n;
  logic [GCD_W-1:0] data_n;
  logic             err_n;

`ifdef GCD_REQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd;
  logic [WW-1:0] wd_n;
  logic          tmo_q;
  logic          tmo_n;
  logic          wd_hit;
  assign wd_hit = wd == WW'(TIMEOUT - 1);
`endif

  assign req_pair  = '{u: req_u, v: req_v};
  assign req_ready = ~full;
  assign push      = req_valid & ~full;
  // done stays high across a new load, so only its edge means "finished"
  assign rise      = gcd_done & ~done_q;

  gcd_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .resetb(resetb),
    .push  (push),
    .pop   (pop),
    .din   (req_pair),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    u_n     = gcd_u;
    v_n     = gcd_v;
    data_n  = rsp_data;
    err_n   = rsp_err;
`ifdef GCD_REQ_TIMEOUT_EN
    wd_n    = '0;
    tmo_n   = tmo_q;
`endif
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          u_n = head.u;
          v_n = head.v;
          // engine never terminates on a zero operand
          if (head.u == '0 || head.v == '0) begin
            data_n  = '0;
            err_n   = 1'b1;
            state_n = RESP;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_n = WAIT;
`ifdef GCD_REQ_TIMEOUT_EN
        wd_n = WW'(1);
`endif
      end
      WAIT: begin
`ifdef GCD_REQ_TIMEOUT_EN
        wd_n = wd + 1'b1;
`endif
        if (rise) begin
          data_n  = gcd_res;
          err_n   = 1'b0;
          state_n = RESP;
        end
`ifdef GCD_REQ_TIMEOUT_EN
        else if (wd_hit) begin
          data_n  = '0;
          err_n   = 1'b1;
          tmo_n   = 1'b1;
          state_n = RESP;
        end
`endif
      end
      RESP: begin
`ifdef GCD_REQ_TIMEOUT_EN
        if (rise) tmo_n = 1'b0;
        if (rsp_ready)
          state_n = (tmo_q && !rise) ? DRAIN : IDLE;
`else
        if (rsp_ready) state_n = IDLE;
`endif
      end
`ifdef GCD_REQ_TIMEOUT_EN
      DRAIN: begin
        if (rise) begin
          tmo_n   = 1'b0;
          state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      state    <= IDLE;
      gcd_u    <= '0;
      gcd_v    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      done_q   <= 1'b0;
`ifdef GCD_REQ_TIMEOUT_EN
      wd       <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      gcd_u    <= u_n;
      gcd_v    <= v_n;
      rsp_data <= data_n;
      rsp_err  <= err_n;
      done_q   <= gcd_done;
`ifdef GCD_REQ_TIMEOUT_EN
      wd       <= wd_n;
      tmo_q    <= tmo_n;
`endif
    end
  end

  assign gcd_ld    = state == ISSUE;
  assign rsp_valid = state == RESP;
  assign busy      = !empty || state != IDLE;

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester: behavioural GCD engine, queue scoreboard,
// directed and random steps; timeout steps need GCD_REQ_TIMEOUT_EN.
module tb_gcd_requester;

  logic       clk = 1'b0;
  logic       resetb = 1'b1;
  logic       req_valid, req_ready;
  logic [7:0] req_u, req_v;
  logic       gcd_ld;
  logic [7:0] gcd_u, gcd_v, gcd_res;
  logic       gcd_done;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err, busy;

  gcd_requester #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .resetb(resetb),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_u(req_u), .req_v(req_v),
    .gcd_ld(gcd_ld), .gcd_u(gcd_u), .gcd_v(gcd_v),
    .gcd_res(gcd_res), .gcd_done(gcd_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] d;
    logic       e;
  } exp_t;
  exp_t expq[$];

  function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return 8'(x);
  endfunction

  function automatic exp_t model(input logic [7:0] u, input logic [7:0] v);
    exp_t r;
    if (u == 0 || v == 0) begin r.d = 8'd0; r.e = 1'b1; end
    else begin r.d = ref_gcd(u, v); r.e = 1'b0; end
    return r;
  endfunction

  // Engine: done falls 2 edges after load, rises lat edges later.
  int lat = 3;
  int force_res = -1;
  int ecnt = 0;
  logic [7:0] eu = 0, ev = 0;
  always @(posedge clk or posedge resetb) begin
    if (resetb) begin
      gcd_done <= 1'b0; gcd_res <= 8'd0; ecnt <= 0;
    end else if (gcd_ld) begin
      ecnt <= 1; eu <= gcd_u; ev <= gcd_v;
    end else if (ecnt > 0) begin
      ecnt <= ecnt + 1;
      if (ecnt == 2) gcd_done <= 1'b0;
      if (ecnt == 2 + lat) begin
        gcd_done <= 1'b1;
        gcd_res <= (force_res >= 0) ? 8'(force_res) : ref_gcd(eu, ev);
        ecnt <= 0;
      end
    end
  end

  int ld_cnt = 0, ld_long = 0, stab_err = 0;
  logic ld_prev = 1'b0;
  always @(negedge clk) begin
    if (gcd_ld) ld_cnt++;
    if (gcd_ld && ld_prev) ld_long++;
    ld_prev = gcd_ld;
    if (ecnt > 0 && !gcd_ld && (gcd_u !== eu || gcd_v !== ev)) stab_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] u, input logic [7:0] v);
    int t;
    t = 0;
    req_u = u; req_v = v; req_valid = 1'b1;
    while (!req_ready && t < 300) begin @(negedge clk); t++; end
    chk("push_accept", t < 300, 1);
    @(negedge clk);
    req_valid = 1'b0;
    expq.push_back(model(u, v));
  endtask

  task automatic collect(input int n);
    for (int k = 0; k < n; k++) begin
      int t;
      exp_t e;
      t = 0;
      while (!(rsp_valid && rsp_ready) && t < 300) begin @(negedge clk); t++; end
      chk("rsp_arrive", t < 300, 1);
      chk("rsp_expected", expq.size() > 0, 1);
      if (t < 300 && expq.size() > 0) begin
        e = expq.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_err", rsp_err, e.e);
      end
      @(negedge clk);
    end
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_gcd_ld"}, gcd_ld, 0);
    chk({tag, "_gcd_u"}, gcd_u, 0);
    chk({tag, "_gcd_v"}, gcd_v, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int base, t, t_ld, bad;
    logic [7:0] d0, u, v;
    logic e0;
    exp_t x;

    req_valid = 0; req_u = 0; req_v = 0; rsp_ready = 1;
    repeat (2) @(negedge clk);
    reset_vals("reset");
    resetb = 1'b0;
    @(negedge clk);

    // single pair with timing of the load pulse
    base = ld_cnt;
    push(48, 18);
    chk("busy_after_push", busy, 1);
    @(negedge clk);
    chk("ld_timing", gcd_ld, 1);
    chk("ld_gcd_u", gcd_u, 48);
    chk("ld_gcd_v", gcd_v, 18);
    collect(1);
    repeat (3) @(negedge clk);
    chk("single_ld_count", ld_cnt - base, 1);

    // zero operands: error response, no load
    base = ld_cnt;
    push(0, 7);
    @(negedge clk);
    chk("zero_u_rsp_timing", rsp_valid, 1);
    collect(1);
    push(9, 0);
    @(negedge clk);
    chk("zero_v_rsp_timing", rsp_valid, 1);
    collect(1);
    repeat (3) @(negedge clk);
    chk("zero_no_ld", ld_cnt - base, 0);

    // fill the FIFO behind a stalled response
    rsp_ready = 0; lat = 3; base = ld_cnt;
    push(12, 8); push(7, 7); push(255, 1); push(128, 64); push(200, 150);
    req_u = 36; req_v = 24; req_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_ready_low", req_ready, 0);
    chk("full_busy", busy, 1);
    fork
      push(36, 24);
      begin rsp_ready = 1; collect(6); end
    join
    repeat (3) @(negedge clk);
    chk("fill_ld_count", ld_cnt - base, 6);

    // backpressure in RESP
    rsp_ready = 0; base = ld_cnt;
    push(30, 12);
    t = 0;
    while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
    chk("bp_valid", rsp_valid, 1);
    d0 = rsp_data; e0 = rsp_err; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== d0 || rsp_err !== e0) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_one_ld", ld_cnt - base, 1);
    rsp_ready = 1;
    collect(1);

    // stale done level carried across a new load
    chk("stale_pre_done", gcd_done, 1);
    force_res = 3; lat = 5; base = ld_cnt;
    push(10, 4);
    void'(expq.pop_back());
    x.d = 8'd3; x.e = 1'b0;
    expq.push_back(x);
    collect(1);
    bad = 0;
    repeat (15) begin @(negedge clk); if (rsp_valid) bad++; end
    chk("stale_one_rsp", bad, 0);
    chk("stale_one_ld", ld_cnt - base, 1);
    force_res = -1;

    // random pairs, some zero
    for (int i = 0; i < 10; i++) begin
      u = 8'($urandom_range(0, 255));
      v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) u = 8'd0;
      lat = $urandom_range(1, 6);
      push(u, v);
      collect(1);
    end

`ifdef GCD_REQ_TIMEOUT_EN
    // watchdog fires, late done is swallowed in DRAIN
    lat = 80;
    push(20, 8);
    void'(expq.pop_back());
    t = 0;
    while (!gcd_ld && t < 20) begin @(negedge clk); t++; end
    t_ld = cyc;
    t = 0;
    while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
    chk("tmo_latency", cyc - t_ld, 64);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_data", rsp_data, 0);
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("drain_busy", busy, 1);
    t = 0; bad = 0;
    while (busy && t < 100) begin
      if (rsp_valid) bad++;
      @(negedge clk); t++;
    end
    chk("drain_done", busy, 0);
    chk("drain_no_rsp", bad, 0);
    lat = 3;
    push(21, 14);
    collect(1);
`endif

    // asynchronous reset while waiting on the engine
    lat = 40;
    push(50, 20); push(9, 3); push(8, 4);
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #1 resetb = 1'b1;
    #1;
    reset_vals("midreset");
    expq.delete();
    @(negedge clk);
    resetb = 1'b0;
    @(negedge clk);
    lat = 3;
    push(14, 21);
    collect(1);
    repeat (10) @(negedge clk);
    chk("post_reset_no_rsp", rsp_valid, 0);
    chk("post_reset_idle", busy, 0);

    chk("ld_width", ld_long, 0);
    chk("operand_stable", stab_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
